// File: rtl/memory_arbiter_if.sv
// Client and memory-side bundle of the two-port memory arbiter.
// The slave modport is the arbiter's view; the master modport is the clients and memory.
interface memory_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int SECTOR_BITS = 4
);
  logic                              req0_valid;
  logic                              req0_write;
  logic [ADDR_WIDTH-1:0]             req0_addr;
  logic [DATA_WIDTH-1:0]             req0_wdata;
  logic                              req0_ready;
  logic                              req1_valid;
  logic                              req1_write;
  logic [ADDR_WIDTH-1:0]             req1_addr;
  logic [DATA_WIDTH-1:0]             req1_wdata;
  logic                              req1_ready;
  logic                              rsp0_valid;
  logic [DATA_WIDTH-1:0]             rsp0_rdata;
  logic                              rsp1_valid;
  logic [DATA_WIDTH-1:0]             rsp1_rdata;
  logic                              erase_start;
  logic [ADDR_WIDTH-SECTOR_BITS-1:0] erase_sector;
  logic                              erase_busy;
  logic                              erase_done;
  logic                              mem_write_enable;
  logic [ADDR_WIDTH-1:0]             mem_write_address;
  logic [ADDR_WIDTH-1:0]             mem_read_address;
  logic [DATA_WIDTH-1:0]             mem_data_in;
  logic [DATA_WIDTH-1:0]             mem_data_out;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  erase_start, erase_sector, mem_data_out,
    output req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output erase_busy, erase_done,
    output mem_write_enable, mem_write_address, mem_read_address, mem_data_in
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output erase_start, erase_sector, mem_data_out,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  erase_busy, erase_done,
    input  mem_write_enable, mem_write_address, mem_read_address, mem_data_in
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory write port and one read port between two clients,
// plus a hardware sector-erase sequencer. All memory-side outputs are registered.
module memory_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int SECTOR_BITS = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  memory_arbiter_if.slave bus
);
  localparam int SEC_W = ADDR_WIDTH - SECTOR_BITS;

  typedef enum logic {IDLE, ERASE} state_t;

  state_t                 state;
  logic                   busy_q;
  logic                   done_q;
  logic [SECTOR_BITS-1:0] cnt_q;
  logic [SEC_W-1:0]       sector_q;
  logic                   last_q;

  logic                   block;
  logic                   start_acc;
  logic                   ready0;
  logic                   ready1;
  logic                   accept;
  logic                   sel_write;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  logic                   we_p1;
  logic [ADDR_WIDTH-1:0]  waddr_p1;
  logic [ADDR_WIDTH-1:0]  raddr_p1;
  logic [DATA_WIDTH-1:0]  din_p1;
  logic                   vld_p1;
  logic                   tag_p1;

  logic                   vld0_p2;
  logic                   vld1_p2;
  logic [DATA_WIDTH-1:0]  rdata0_p2;
  logic [DATA_WIDTH-1:0]  rdata1_p2;

  // Erase owns the memory from the start request until erase_busy drops; reset also forces readies low.
  assign block     = !reset_n || busy_q || bus.erase_start;
  assign start_acc = (state == IDLE) && !busy_q && bus.erase_start;
  assign ready0    = !block && bus.req0_valid && (!bus.req1_valid || last_q);
  assign ready1    = !block && bus.req1_valid && (!bus.req0_valid || !last_q);
  assign accept    = ready0 || ready1;

  always_comb begin
    sel_write = bus.req0_write;
    sel_addr  = bus.req0_addr;
    sel_wdata = bus.req0_wdata;
    if (ready1) begin
      sel_write = bus.req1_write;
      sel_addr  = bus.req1_addr;
      sel_wdata = bus.req1_wdata;
    end
  end

  // Erase FSM: busy is held one cycle past the last issue so it covers the done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      sector_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (done_q) busy_q <= 1'b0;
          if (start_acc) begin
            state    <= ERASE;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            sector_q <= bus.erase_sector;
          end
        end
        ERASE: begin
          if (&cnt_q) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Issue stage: load memory-side registers from an erase step or an accepted request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      raddr_p1 <= '0;
      din_p1   <= '0;
      vld_p1   <= 1'b0;
      tag_p1   <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      we_p1  <= 1'b0;
      vld_p1 <= 1'b0;
      if (state == ERASE) begin
        we_p1    <= 1'b1;
        waddr_p1 <= {sector_q, cnt_q};
        din_p1   <= '0;
      end else if (accept) begin
        last_q <= ready1;
        if (sel_write) begin
          we_p1    <= 1'b1;
          waddr_p1 <= sel_addr;
          din_p1   <= sel_wdata;
        end else begin
          raddr_p1 <= sel_addr;
          vld_p1   <= 1'b1;
          tag_p1   <= ready1;
        end
      end
    end
  end

  // Response stage: capture asynchronous read data at the end of the memory cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld0_p2   <= 1'b0;
      vld1_p2   <= 1'b0;
      rdata0_p2 <= '0;
      rdata1_p2 <= '0;
    end else begin
      vld0_p2 <= vld_p1 && !tag_p1;
      vld1_p2 <= vld_p1 && tag_p1;
      if (vld_p1 && !tag_p1) rdata0_p2 <= bus.mem_data_out;
      if (vld_p1 && tag_p1)  rdata1_p2 <= bus.mem_data_out;
    end
  end

  assign bus.req0_ready        = ready0;
  assign bus.req1_ready        = ready1;
  assign bus.rsp0_valid        = vld0_p2;
  assign bus.rsp1_valid        = vld1_p2;
  assign bus.rsp0_rdata        = rdata0_p2;
  assign bus.rsp1_rdata        = rdata1_p2;
  assign bus.erase_busy        = busy_q;
  assign bus.erase_done        = done_q;
  assign bus.mem_write_enable  = we_p1;
  assign bus.mem_write_address = waddr_p1;
  assign bus.mem_read_address  = raddr_p1;
  assign bus.mem_data_in       = din_p1;
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter and sequencer that sits directly in front of the `memory` array. It shares the array's single write port and single read port between two client ports using round-robin arbitration. It also implements sector erase as a hardware sequence that writes zero to every word of a selected sector. All memory-side outputs are registered, and the memory's own `reset` input is tied low by the integrator.

## Interface
- `DATA_WIDTH`, default 32: word width. Must match the memory.
- `ADDR_WIDTH`, default 8: word address width. Must match the memory.
- `SECTOR_BITS`, default 4: log2 of words per sector. Must satisfy 1 ≤ SECTOR_BITS < ADDR_WIDTH.

Ports:
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request present on port 0 / 1.
- `req0_write` / `req1_write` in 1: 1 = write, 0 = read.
- `req0_addr` / `req1_addr` in ADDR_WIDTH: word address.
- `req0_wdata` / `req1_wdata` in DATA_WIDTH: write data.
- `req0_ready` / `req1_ready` out 1: grant. A request is accepted on a cycle where valid & ready.
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle pulse carrying read data.
- `rsp0_rdata` / `rsp1_rdata` out DATA_WIDTH: read data. Valid only while the matching rsp_valid is 1.
- `erase_start` in 1: request a sector erase.
- `erase_sector` in ADDR_WIDTH-SECTOR_BITS: sector index, sampled when a start is accepted.
- `erase_busy` out 1: an erase sequence is in progress.
- `erase_done` out 1: one-cycle pulse on the last erase write.
- `mem_write_enable` out 1: registered, to memory `write_enable`.
- `mem_write_address`, `mem_read_address` out ADDR_WIDTH: registered.
- `mem_data_in` out DATA_WIDTH: registered.
- `mem_data_out` in DATA_WIDTH: asynchronous read data from memory.

## Operation
- FSM states:
  - IDLE → ERASE when `erase_start`=1 in IDLE.
  - ERASE → IDLE after the last erase issue. Then `erase_done` pulses in the following cycle, and `erase_busy` falls after it.
- Ready rules:
  - Both readies are combinational.
  - Both are 0 while `erase_busy`=1, and in any IDLE cycle with `erase_start`=1 (erase has priority).
  - At most one ready is high per cycle.
  - Ready goes only to a port whose valid is 1.
- Round-robin arbitration:
  - A 1-bit `last` register records the port last granted. It resets to 1, so port 0 wins the first contention.
  - If both ports are valid, the port ≠ `last` is granted.
  - If only one port is valid, it is granted regardless of `last`.
  - `last` updates only on an accepted request.
- Issue: an accepted request, or one erase step, loads the memory-side registers on that edge.
  - Write: `mem_write_enable`=1, `mem_write_address`=addr, `mem_data_in`=wdata.
  - Read: `mem_write_enable`=0, `mem_read_address`=addr. A 1-bit tag records the requesting port.
- Read response: `mem_data_out` is captured into the tagged port's `rdata` at the end of the memory cycle, and that port's `rsp_valid` pulses in the next cycle. There is no response backpressure.
- Cycles with nothing issued drive `mem_write_enable`=0. The address and data registers hold their values.
- Erase sequencing:
  - The base address is `{erase_sector, SECTOR_BITS'b0}`.
  - A SECTOR_BITS-wide counter steps from 0 to 2^SECTOR_BITS−1, issuing one write of 0 per cycle to base+count.
  - The counter does not wrap into the next sector.
- `erase_start` while `erase_busy`=1 is ignored. The erase is not queued.
- A read issued in the cycle before erase start still completes and returns its response normally.

## Timing
- Reset values (while `reset_n`=0):
  - All readies, rsp_valids, `erase_busy`, `erase_done`, and `mem_write_enable` are 0.
  - All addresses, data, and rdata outputs are 0.
  - FSM is in IDLE, `last`=1, any in-flight read is dropped.
- Reset asserted mid-erase aborts the erase immediately. No `erase_done` pulse is produced.
- Write latency: accepted at edge N, memory port driven in cycle N+1, committed at edge N+1.
- Read latency: accepted at edge N, `rsp_valid` high in cycle N+2.
- Throughput: one request per cycle sustained. Back-to-back reads from alternating ports must be supported.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at N+1 returns the new data.
- Erase timing: start accepted at edge E, so `erase_busy` is high for cycles E+1 … E+2^SECTOR_BITS+1.
  - Erase writes appear on the memory port in cycles E+2 … E+2^SECTOR_BITS+1.
  - `erase_done` is high in cycle E+2^SECTOR_BITS+1 only.

## Test plan
- Single port: port 0 writes 0xDEADBEEF to address 0x10, then reads 0x10. Required: `rsp0_valid` pulses 2 cycles after the read is accepted, with `rsp0_rdata`=0xDEADBEEF, and `rsp1_valid` stays 0.
- Contention: both ports hold valid reads for 6 cycles starting right after reset. Required: grants go 0,1,0,1,0,1, and each response is routed to the correct port with the correct data.
- Read-after-write across ports: port 1 writes 0x5A5A5A5A to 0x22 and port 0 reads 0x22 on the next accepted cycle. Required: `rsp0_rdata`=0x5A5A5A5A.
- Erase: preload sector 3 (addresses 0x30–0x3F) with non-zero data, then pulse `erase_start` with `erase_sector`=3 while both ports are valid.
  - Required: both readies are 0 for 18 cycles and `erase_done` pulses once.
  - Reads of 0x30–0x3F then return 0, and 0x2F and 0x40 are unchanged.
  - A second `erase_start` pulsed mid-erase has no effect.
- Reset mid-erase: assert `reset_n`=0 at the 8th erase write. Required: all outputs return to reset values immediately, no `erase_done` pulse, and port 0 is granted first after release.
